pc_target_unit: RTL
===================

Name: pc_target_unit

Overview:
- Registered program-counter unit for the multicycle MIPS datapath. It generalises the combinational jump-target concatenation into a full next-PC generator.
- Owns the PC register and supports four target modes: sequential, branch, region jump and register jump.
- Optionally captures a link address.
- Detects misaligned targets and runs a two-state trap sequence that redirects fetch to an exception vector.
- Sits between the control unit (mode/write strobes) and the instruction memory address mux.

Parameters:
- ADDR_W, 32, PC / address width in bits.
- REGION_W, 4, upper PC bits preserved by region jumps; instr_index width = ADDR_W-REGION_W-2.
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- EXC_VECTOR, 32'h0000_00FC, PC loaded when a misalignment trap is taken (must be word-aligned).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_write  in  1  load a new PC this cycle (unconditional update).
- pc_mode  in  2  target select: 00 seq, 01 branch, 10 region jump, 11 register jump.
- branch_cond  in  1  branch condition from ALU; only used when pc_mode=01.
- link_en  in  1  capture link address together with this update.
- imm16  in  16  branch offset in words, signed.
- instr_index  in  ADDR_W-REGION_W-2  jump index field (rs,rt,imm packed for 32-bit config).
- reg_target  in  ADDR_W  register-jump target.
- pc  out  ADDR_W  current PC.
- link_addr  out  ADDR_W  last captured return address.
- epc  out  ADDR_W  PC of the instruction that trapped.
- bad_addr  out  ADDR_W  offending misaligned target.
- exc_misalign  out  1  one-cycle pulse on trap entry.
- trap_busy  out  1  high while state=TRAP.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC; link_addr=0, epc=0, bad_addr=0.
  - exc_misalign=0, trap_busy=0, state=RUN.
- Internal pc_plus4 = pc + 4, modulo 2^ADDR_W (wraps, no flag).
- Target computation (combinational):
  - seq: pc_plus4.
  - branch: pc_plus4 + (sign-extend imm16 to ADDR_W) << 2, modulo 2^ADDR_W, when branch_cond=1; otherwise pc_plus4.
  - region jump: {pc_plus4[ADDR_W-1 -: REGION_W], instr_index, 2'b00}.
  - register jump: reg_target.
- Misaligned = target[1:0] != 0. Only register jump can produce this.
- States RUN and TRAP.
- RUN, pc_write=1, aligned target:
  - pc <= target on the next edge (1-cycle latency; pc visible the cycle after the strobe).
  - If link_en=1, link_addr <= pc_plus4 on the same edge.
- RUN, pc_write=1, misaligned target:
  - pc unchanged; epc <= pc; bad_addr <= target.
  - exc_misalign <= 1 for exactly one cycle; state <= TRAP.
  - link_addr NOT updated, even with link_en=1.
- RUN, pc_write=0: all registers hold; link_en ignored.
- TRAP (exactly one cycle):
  - pc <= EXC_VECTOR; state <= RUN; trap_busy=1 during this cycle.
  - pc_write, link_en and all target inputs are ignored, including any strobe arriving in the TRAP cycle.
- exc_misalign is registered:
  - Asserts in the same cycle trap_busy first goes high.
  - Deasserts the following cycle.
- Back-to-back pc_write in consecutive RUN cycles: each loads; no bubble.
- Reset asserted mid-trap: state returns to RUN, pc=RESET_PC; the pending vector load is abandoned.
- Outputs are all direct register outputs; no combinational path from inputs to outputs.

Test Plan:
- Reset release with default params:
  - -> pc=0x00000000, trap_busy=0.
  - Then 3 cycles of pc_write=1, mode=00 -> pc=4, 8, 0xC on successive cycles.
- Branch:
  - pc=0x00000100, mode=01, cond=1, imm16=0xFFFE -> pc=0x000000FC.
  - Same with cond=0 -> pc=0x00000104.
  - imm16=0x7FFF from pc=0x00000000 -> pc=0x00020000.
- Region jump at boundary:
  - pc=0x1FFFFFFC, mode=10, instr_index=0x0000010 -> pc=0x20000040 (region taken from pc+4).
  - From pc=0x10000000 with the same index -> pc=0x10000040.
- Register jump with link:
  - pc=0x00400020, mode=11, reg_target=0x00400100, link_en=1 -> pc=0x00400100, link_addr=0x00400024.
- Misaligned jump:
  - pc=0x00000040, mode=11, reg_target=0x00000102, link_en=1 -> next cycle: pc=0x40, epc=0x40, bad_addr=0x102, exc_misalign=1, trap_busy=1, link_addr unchanged.
  - Cycle after: pc=0x000000FC, exc_misalign=0, trap_busy=0.
  - A pc_write issued during TRAP is ignored.
- Reset mid-trap:
  - Assert reset asynchronously during the TRAP cycle -> pc=0 immediately, trap_busy=0.
  - After release, pc does not become 0xFC.

Source files
------------

// File: rtl/pc_target_unit.sv
// pc_target_unit: registered next-PC generator with link capture and misalignment trap
module pc_target_unit #(
  parameter int                ADDR_W     = 32,
  parameter int                REGION_W   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'('hFC)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         pc_write_i,
  input  logic [1:0]                   pc_mode_i,
  input  logic                         branch_cond_i,
  input  logic                         link_en_i,
  input  logic [15:0]                  imm16_i,
  input  logic [ADDR_W-REGION_W-3:0]   instr_index_i,
  input  logic [ADDR_W-1:0]            reg_target_i,
  output logic [ADDR_W-1:0]            pc_o,
  output logic [ADDR_W-1:0]            link_addr_o,
  output logic [ADDR_W-1:0]            epc_o,
  output logic [ADDR_W-1:0]            bad_addr_o,
  output logic                         exc_misalign_o,
  output logic                         trap_busy_o
);
  typedef enum logic {RUN, TRAP} state_e;
  state_e            state_q;
  logic [ADDR_W-1:0] pc_q, link_q, epc_q, bad_q;
  logic [ADDR_W-1:0] pc_plus4, br_off, target;
  logic              exc_q, misaligned;
  // Candidate next PC for the selected mode; only a register jump can be misaligned
  always_comb begin
    pc_plus4   = pc_q + ADDR_W'(4);
    br_off     = {{(ADDR_W-18){imm16_i[15]}}, imm16_i, 2'b00};
    target     = pc_mode_i == 2'b00 ? pc_plus4 :
                 pc_mode_i == 2'b01 ? (branch_cond_i ? pc_plus4 + br_off : pc_plus4) :
                 pc_mode_i == 2'b10 ? {pc_plus4[ADDR_W-1 -: REGION_W], instr_index_i, 2'b00} :
                 reg_target_i;
    misaligned = |target[1:0];
  end
  // RUN loads the target or enters TRAP; TRAP redirects to the vector for one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      link_q  <= '0;
      epc_q   <= '0;
      bad_q   <= '0;
      exc_q   <= 1'b0;
    end else if (state_q == TRAP) begin
      pc_q    <= EXC_VECTOR;
      state_q <= RUN;
      exc_q   <= 1'b0;
    end else begin
      exc_q <= 1'b0;
      if (pc_write_i && misaligned) begin
        epc_q   <= pc_q;
        bad_q   <= target;
        exc_q   <= 1'b1;
        state_q <= TRAP;
      end else if (pc_write_i) begin
        pc_q <= target;
        if (link_en_i) link_q <= pc_plus4;
      end
    end
  end
  assign pc_o           = pc_q;
  assign link_addr_o    = link_q;
  assign epc_o          = epc_q;
  assign bad_addr_o     = bad_q;
  assign exc_misalign_o = exc_q;
  assign trap_busy_o    = state_q == TRAP;
endmodule
